// File: rtl/glb_rx_ppe_sync_ctrl.sv
// glb_rx_ppe_sync_ctrl
// Global RX control: broadcasts a shared-table sync to N_PPE lanes and
// collects one ack per lane. Each round has a per-lane enable mask, an
// optional timeout that captures which lanes are missing, and an epoch
// counter of successful rounds.
//
// Ports:
//   cclk, rst_n          core clock, asynchronous active-low reset
//   req_valid/req_ready  round request handshake (ready only when idle)
//   req_mask, tmo_limit  participating lanes and ack timeout (0 = none),
//                        sampled at accept
//   glb_sync  [N_PPE]    per-lane sync level, drops after that lane acks
//   glb_ack   [N_PPE]    per-lane ack pulse
//   done, timeout        1-cycle round completion / abort pulses
//   ack_missing [N_PPE]  lanes still outstanding at the last timeout
//   epoch     [EPOCH_W]  wrapping count of successful rounds
//
// Optional feature (macro GLB_RX_PPE_SPURIOUS_CNT_EN): adds output
// spurious_cnt[15:0], a saturating count of ignored ack bits.
module glb_rx_ppe_sync_ctrl #(
    parameter int unsigned N_PPE   = 4,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned EPOCH_W = 8
) (
    input  logic               cclk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [N_PPE-1:0]   req_mask,
    input  logic [TMO_W-1:0]   tmo_limit,
    output logic [N_PPE-1:0]   glb_sync,
    input  logic [N_PPE-1:0]   glb_ack,
    output logic               done,
    output logic               timeout,
    output logic [N_PPE-1:0]   ack_missing,
    output logic [EPOCH_W-1:0] epoch
`ifdef GLB_RX_PPE_SPURIOUS_CNT_EN
    ,
    output logic [15:0]        spurious_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_PPE-1:0]   mask_q, mask_d;
    logic [TMO_W-1:0]   lim_q, lim_d;
    logic [N_PPE-1:0]   ack_seen_q, ack_seen_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               req_ready_q, req_ready_d;
    logic [N_PPE-1:0]   glb_sync_q, glb_sync_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [N_PPE-1:0]   ack_missing_q, ack_missing_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [N_PPE-1:0]   outstanding;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        lim_d         = lim_q;
        ack_seen_d    = ack_seen_q;
        tmo_cnt_d     = tmo_cnt_q;
        glb_sync_d    = glb_sync_q;
        done_d        = 1'b0;
        timeout_d     = 1'b0;
        ack_missing_d = ack_missing_q;
        epoch_d       = epoch_q;
        outstanding   = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d       = S_SYNC;
                    mask_d        = req_mask;
                    lim_d         = tmo_limit;
                    ack_seen_d    = '0;
                    tmo_cnt_d     = '0;
                    ack_missing_d = '0;
                    glb_sync_d    = req_mask;
                end
            end
            S_SYNC: begin
                ack_seen_d  = ack_seen_q | (glb_ack & mask_q);
                outstanding = mask_q & ~ack_seen_d;
                glb_sync_d  = outstanding;
                if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
                // Completion is checked first so a last ack beats a same-cycle timeout
                if (outstanding == '0) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    glb_sync_d = '0;
                    epoch_d    = epoch_q + EPOCH_W'(1);
                end else if ((lim_q != '0) && (tmo_cnt_q == lim_q)) begin
                    state_d       = S_ERR;
                    timeout_d     = 1'b1;
                    glb_sync_d    = '0;
                    ack_missing_d = outstanding;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            lim_q         <= '0;
            ack_seen_q    <= '0;
            tmo_cnt_q     <= '0;
            req_ready_q   <= 1'b1;
            glb_sync_q    <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            ack_missing_q <= '0;
            epoch_q       <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            lim_q         <= lim_d;
            ack_seen_q    <= ack_seen_d;
            tmo_cnt_q     <= tmo_cnt_d;
            req_ready_q   <= req_ready_d;
            glb_sync_q    <= glb_sync_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            ack_missing_q <= ack_missing_d;
            epoch_q       <= epoch_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign glb_sync    = glb_sync_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign ack_missing = ack_missing_q;
    assign epoch       = epoch_q;

`ifdef GLB_RX_PPE_SPURIOUS_CNT_EN
    logic [N_PPE-1:0] ignored;
    logic [16:0]      spur_sum;
    logic [15:0]      spur_q, spur_d;

    // Ignored ack bits: everything outside SYNC, else unmasked or already-acked lanes
    always_comb begin
        ignored = glb_ack;
        if (state_q == S_SYNC) begin
            ignored = glb_ack & ~(mask_q & ~ack_seen_q);
        end
        spur_sum = {1'b0, spur_q};
        for (int i = 0; i < int'(N_PPE); i++) begin
            spur_sum = spur_sum + 17'(ignored[i]);
        end
        spur_d = spur_sum[16] ? 16'hFFFF : spur_sum[15:0];
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            spur_q <= '0;
        end else begin
            spur_q <= spur_d;
        end
    end

    assign spurious_cnt = spur_q;
`endif

endmodule
